tt_um_hoene_line_decoder: RTL and testbench

// - Upstream stage of the protocol block: turns the raw single-wire LED input (DIN/BIN pad) into
//   in_data / in_clk / in_frame / bit_counter for the protocol stage.
// - Encoding is pulse width. Each bit starts on a rising edge. High time >= THRESHOLD clk cycles is 1,

---
 rtl/tt_um_hoene_line_decoder_if.sv | 19 +
 rtl/tt_um_hoene_line_decoder.sv | 167 ++++++++++++++++
 tb/tb_tt_um_hoene_line_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_hoene_line_decoder_if.sv
// Line-decoder bus: raw single-wire input plus the decoded bit/strobe/frame outputs.
interface tt_um_hoene_line_decoder_if;
    logic       din;
    logic       out_data;
    logic       out_clk;
    logic       out_frame;
    logic [4:0] bit_counter;
    logic       error;

    modport master (
        output din,
        input  out_data, out_clk, out_frame, bit_counter, error
    );

    modport slave (
        input  din,
        output out_data, out_clk, out_frame, bit_counter, error
    );
endinterface

// File: rtl/tt_um_hoene_line_decoder.sv
// Pulse-width line decoder: synchronizes din, measures high time, emits one strobe per bit.
// Optional macro LINE_DECODER_GLITCH_FILTER_EN adds a 2-cycle stability filter on the line.
//
// state  | meaning
// S_IDLE | no frame; waiting for a rising edge on an armed line
// S_HIGH | measuring the high time of the current bit
// S_LOW  | measuring the gap after a bit; long gap ends the frame
module tt_um_hoene_line_decoder #(
    parameter int CNT_W         = 8,
    parameter int THRESHOLD     = 24,
    parameter int IDLE_TIMEOUT  = 200,
    parameter int STUCK_TIMEOUT = 128,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    tt_um_hoene_line_decoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] L_THRESH = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] L_IDLE   = CNT_W'(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] L_STUCK  = CNT_W'(STUCK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_armed;
    logic                   r_prev_s;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out_data;
    logic                   r_out_clk;
    logic                   r_out_frame;
    logic [4:0]             r_bit_counter;
    logic                   r_error;

    logic                   w_din_sync;
    logic                   w_line_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_din_sync = r_sync[SYNC_STAGES-1];

    // r_armed only sets once the synchronizer holds real samples showing a low line,
    // so a line that is already high out of reset cannot fake a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.din};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            if (r_sync_vld[SYNC_STAGES-1] && !w_din_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef LINE_DECODER_GLITCH_FILTER_EN
    logic r_filt_prev;
    logic r_line_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_prev <= 1'b0;
            r_line_s    <= 1'b0;
        end else begin
            r_filt_prev <= w_din_sync;
            if (w_din_sync == r_filt_prev) begin
                r_line_s <= w_din_sync;
            end
        end
    end

    assign w_line_s = r_line_s;
`else
    assign w_line_s = w_din_sync;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_s <= 1'b0;
        end else begin
            r_prev_s <= w_line_s;
        end
    end

    assign w_rise    = w_line_s & ~r_prev_s;
    assign w_fall    = ~w_line_s & r_prev_s;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_out_data    <= 1'b0;
            r_out_clk     <= 1'b0;
            r_out_frame   <= 1'b0;
            r_bit_counter <= 5'd0;
            r_error       <= 1'b0;
        end else begin
            r_out_clk <= 1'b0;
            r_error   <= 1'b0;
            // Index advances the cycle after its strobe; frame-end branches below override it.
            if (r_out_clk) begin
                r_bit_counter <= r_bit_counter + 5'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise && r_armed) begin
                        r_state     <= S_HIGH;
                        r_cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
                        r_out_frame <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        r_out_data <= (r_cnt >= L_THRESH);
                        r_out_clk  <= 1'b1;
                        r_state    <= S_LOW;
                        r_cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (w_cnt_inc >= L_STUCK) begin
                        r_error       <= 1'b1;
                        r_out_frame   <= 1'b0;
                        r_bit_counter <= 5'd0;
                        r_state       <= S_IDLE;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_LOW: begin
                    // A rise in the timeout cycle keeps the frame alive.
                    if (w_rise) begin
                        r_state <= S_HIGH;
                        r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (w_cnt_inc >= L_IDLE) begin
                        r_out_frame   <= 1'b0;
                        r_bit_counter <= 5'd0;
                        r_state       <= S_IDLE;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_clk     = r_out_clk;
    assign bus.out_frame   = r_out_frame;
    assign bus.bit_counter = r_bit_counter;
    assign bus.error       = r_error;

endmodule

// File: tb/tb_tt_um_hoene_line_decoder.sv
// Directed bench for the line decoder: frames, gap/threshold boundaries, stuck line, glitch, reset.
module tb_tt_um_hoene_line_decoder;

`ifdef LINE_DECODER_GLITCH_FILTER_EN
    localparam int D = 4;
`else
    localparam int D = 2;
`endif

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    int         n_strobe = 0;
    int         n_err    = 0;
    int         n_dbl    = 0;
    int         n_frame  = 0;
    logic       prev_clk = 1'b0;
    logic       q_data[$];
    logic [4:0] q_bc[$];

    tt_um_hoene_line_decoder_if ld_if ();

    tt_um_hoene_line_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (ld_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ld_if.out_clk === 1'b1) begin
            n_strobe = n_strobe + 1;
            q_data.push_back(ld_if.out_data);
            q_bc.push_back(ld_if.bit_counter);
            if (prev_clk === 1'b1) n_dbl = n_dbl + 1;
        end
        if (ld_if.error === 1'b1) n_err = n_err + 1;
        if (ld_if.out_frame === 1'b1) n_frame = n_frame + 1;
        prev_clk = ld_if.out_clk;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        ld_if.din = 1'b1;
        wait_cyc(hi);
        ld_if.din = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic test_reset();
        int fb;
        int sb;
        rst = 1'b1;
        ld_if.din = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        n_checks++;
        if ({ld_if.out_data, ld_if.out_clk, ld_if.out_frame, ld_if.bit_counter, ld_if.error} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {ld_if.out_data, ld_if.out_clk, ld_if.out_frame, ld_if.bit_counter, ld_if.error});
        end
        fb = n_frame;
        sb = n_strobe;
        wait_cyc(300);
        n_checks++;
        if (n_frame !== fb) begin
            n_errors++;
            $display("FAIL idle_frame_cycles: got %0d expected 0", n_frame - fb);
        end
        n_checks++;
        if (n_strobe !== sb) begin
            n_errors++;
            $display("FAIL idle_strobes: got %0d expected 0", n_strobe - sb);
        end
    endtask

    task automatic test_frame32();
        int sb;
        sb = n_strobe;
        ld_if.din = 1'b1;
        wait_cyc(D);
        n_checks++;
        if (ld_if.out_frame !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_before_rise: got %b expected 0", ld_if.out_frame);
        end
        wait_cyc(1);
        n_checks++;
        if (ld_if.out_frame !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_at_rise: got %b expected 1", ld_if.out_frame);
        end
        wait_cyc(40 - D - 1);
        ld_if.din = 1'b0;
        wait_cyc(20);
        for (int i = 1; i < 32; i++) begin
            if (i % 2 == 1) pulse(10, 50);
            else            pulse(40, 20);
        end
        wait_cyc(D + 199 - 50);
        n_checks++;
        if (ld_if.out_frame !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_before_timeout: got %b expected 1", ld_if.out_frame);
        end
        wait_cyc(1);
        n_checks++;
        if (ld_if.out_frame !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_at_timeout: got %b expected 0", ld_if.out_frame);
        end
        n_checks++;
        if (n_strobe - sb !== 32) begin
            n_errors++;
            $display("FAIL frame32_count: got %0d expected 32", n_strobe - sb);
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (q_data[sb + i] !== ((i % 2 == 0) ? 1'b1 : 1'b0) || q_bc[sb + i] !== 5'(i)) begin
                    n_errors++;
                    $display("FAIL frame32_bit%0d: got data %b idx %0d expected data %0d idx %0d",
                             i, q_data[sb + i], q_bc[sb + i], (i % 2 == 0), i);
                end
            end
        end
    endtask

    task automatic test_gap();
        int sb;
        sb = n_strobe;
        pulse(10, 199);
        ld_if.din = 1'b1;
        wait_cyc(D);
        n_checks++;
        if (ld_if.out_frame !== 1'b1) begin
            n_errors++;
            $display("FAIL gap199_frame: got %b expected 1", ld_if.out_frame);
        end
        wait_cyc(10 - D);
        ld_if.din = 1'b0;
        wait_cyc(200);
        ld_if.din = 1'b1;
        wait_cyc(D);
        n_checks++;
        if (ld_if.out_frame !== 1'b0) begin
            n_errors++;
            $display("FAIL gap200_frame_drop: got %b expected 0", ld_if.out_frame);
        end
        wait_cyc(1);
        n_checks++;
        if (ld_if.out_frame !== 1'b1) begin
            n_errors++;
            $display("FAIL gap200_restart: got %b expected 1", ld_if.out_frame);
        end
        wait_cyc(10 - D - 1);
        ld_if.din = 1'b0;
        wait_cyc(250);
        n_checks++;
        if (n_strobe - sb !== 3) begin
            n_errors++;
            $display("FAIL gap_count: got %0d expected 3", n_strobe - sb);
        end else begin
            n_checks++;
            if ({q_bc[sb], q_bc[sb + 1], q_bc[sb + 2]} !== {5'd0, 5'd1, 5'd0}) begin
                n_errors++;
                $display("FAIL gap_indices: got %0d %0d %0d expected 0 1 0",
                         q_bc[sb], q_bc[sb + 1], q_bc[sb + 2]);
            end
        end
    endtask

    task automatic test_threshold();
        ld_if.din = 1'b1;
        wait_cyc(23);
        ld_if.din = 1'b0;
        wait_cyc(D);
        n_checks++;
        if (ld_if.out_clk !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: got %b expected 0", ld_if.out_clk);
        end
        wait_cyc(1);
        n_checks++;
        if ({ld_if.out_clk, ld_if.out_data, ld_if.bit_counter} !== {1'b1, 1'b0, 5'd0}) begin
            n_errors++;
            $display("FAIL width23: got clk %b data %b idx %0d expected clk 1 data 0 idx 0",
                     ld_if.out_clk, ld_if.out_data, ld_if.bit_counter);
        end
        wait_cyc(1);
        n_checks++;
        if ({ld_if.out_clk, ld_if.bit_counter} !== {1'b0, 5'd1}) begin
            n_errors++;
            $display("FAIL after_strobe: got clk %b idx %0d expected clk 0 idx 1",
                     ld_if.out_clk, ld_if.bit_counter);
        end
        wait_cyc(30 - D - 2);
        ld_if.din = 1'b1;
        wait_cyc(24);
        ld_if.din = 1'b0;
        wait_cyc(D + 1);
        n_checks++;
        if ({ld_if.out_clk, ld_if.out_data, ld_if.bit_counter} !== {1'b1, 1'b1, 5'd1}) begin
            n_errors++;
            $display("FAIL width24: got clk %b data %b idx %0d expected clk 1 data 1 idx 1",
                     ld_if.out_clk, ld_if.out_data, ld_if.bit_counter);
        end
        wait_cyc(1);
        n_checks++;
        if ({ld_if.out_clk, ld_if.out_data} !== 2'b01) begin
            n_errors++;
            $display("FAIL data_hold: got clk %b data %b expected clk 0 data 1",
                     ld_if.out_clk, ld_if.out_data);
        end
        wait_cyc(250);
    endtask

    task automatic test_stuck();
        int sb;
        int eb;
        pulse(40, 20);
        sb = n_strobe;
        eb = n_err;
        ld_if.din = 1'b1;
        wait_cyc(D + 127);
        n_checks++;
        if ({ld_if.error, ld_if.out_frame} !== 2'b01) begin
            n_errors++;
            $display("FAIL stuck_before: got err %b frame %b expected err 0 frame 1",
                     ld_if.error, ld_if.out_frame);
        end
        wait_cyc(1);
        n_checks++;
        if ({ld_if.error, ld_if.out_frame, ld_if.bit_counter} !== {1'b1, 1'b0, 5'd0}) begin
            n_errors++;
            $display("FAIL stuck_fault: got err %b frame %b idx %0d expected err 1 frame 0 idx 0",
                     ld_if.error, ld_if.out_frame, ld_if.bit_counter);
        end
        wait_cyc(1);
        n_checks++;
        if (ld_if.error !== 1'b0) begin
            n_errors++;
            $display("FAIL stuck_pulse_len: got %b expected 0", ld_if.error);
        end
        wait_cyc(200 - D - 129);
        ld_if.din = 1'b0;
        wait_cyc(20);
        n_checks++;
        if (ld_if.out_frame !== 1'b0 || n_strobe !== sb || n_err - eb !== 1) begin
            n_errors++;
            $display("FAIL stuck_aftermath: got frame %b strobes %0d errs %0d expected 0 0 1",
                     ld_if.out_frame, n_strobe - sb, n_err - eb);
        end
        pulse(10, 250);
        n_checks++;
        if (n_strobe - sb !== 1 || q_bc[$] !== 5'd0 || q_data[$] !== 1'b0) begin
            n_errors++;
            $display("FAIL stuck_recover: got strobes %0d idx %0d data %b expected 1 0 0",
                     n_strobe - sb, q_bc[$], q_data[$]);
        end
    endtask

    task automatic test_glitch();
        int sb;
        sb = n_strobe;
        pulse(40, 20);
        pulse(1, 250);
`ifdef LINE_DECODER_GLITCH_FILTER_EN
        n_checks++;
        if (n_strobe - sb !== 1) begin
            n_errors++;
            $display("FAIL glitch_filtered: got %0d strobes expected 1", n_strobe - sb);
        end
`else
        n_checks++;
        if (n_strobe - sb !== 2 || q_data[$] !== 1'b0 || q_bc[$] !== 5'd1) begin
            n_errors++;
            $display("FAIL glitch_strobe: got strobes %0d data %b idx %0d expected 2 0 1",
                     n_strobe - sb, q_data[$], q_bc[$]);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        int sb;
        pulse(40, 20);
        ld_if.din = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(1);
        n_checks++;
        if ({ld_if.out_data, ld_if.out_clk, ld_if.out_frame, ld_if.bit_counter, ld_if.error} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_midframe: got %b expected 0",
                     {ld_if.out_data, ld_if.out_clk, ld_if.out_frame, ld_if.bit_counter, ld_if.error});
        end
        wait_cyc(2);
        rst = 1'b0;
        sb = n_strobe;
        wait_cyc(30);
        n_checks++;
        if (ld_if.out_frame !== 1'b0 || n_strobe !== sb) begin
            n_errors++;
            $display("FAIL high_out_of_reset: got frame %b strobes %0d expected 0 0",
                     ld_if.out_frame, n_strobe - sb);
        end
        ld_if.din = 1'b0;
        wait_cyc(10);
        pulse(10, 250);
        n_checks++;
        if (n_strobe - sb !== 1 || q_bc[$] !== 5'd0 || q_data[$] !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_frame: got strobes %0d idx %0d data %b expected 1 0 0",
                     n_strobe - sb, q_bc[$], q_data[$]);
        end
    endtask

    task automatic test_no_double();
        n_checks++;
        if (n_dbl !== 0) begin
            n_errors++;
            $display("FAIL double_strobe: got %0d expected 0", n_dbl);
        end
    endtask

    initial begin
        rst = 1'b1;
        ld_if.din = 1'b0;
        test_reset();
        test_frame32();
        test_gap();
        test_threshold();
        test_stuck();
        test_glitch();
        test_reset_midframe();
        test_no_double();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
